// File: rtl/bus_arb_pkg.sv
// Shared definitions for the instruction/data bus arbiter: state encoding,
// NOP word returned by a timed-out access, and byte-enable width.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_WAIT = 2'd1,
        ST_D_WAIT = 2'd2
    } arb_state_t;

    localparam int          BE_W     = 4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef logic [BE_W-1:0] be_t;

endpackage

// File: rtl/bus_arb_wdog.sv
// Bus watchdog: counts cycles while a transaction is outstanding and flags
// expiry in the LIMIT-th wait cycle. Only instantiated with BUS_ARB_TIMEOUT_EN.
module bus_arb_wdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    input  logic active,
    output logic expire
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count_r;
    logic          expire_s;

    // Expiry is reached when the count sits at the last allowed wait cycle.
    always_comb begin
        expire_s = 1'b0;
        if (active && (count_r == CW'(LIMIT - 1))) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Wait-cycle counter: restarted on every grant and every completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (start || clear) begin
            count_r <= '0;
        end else if (active && !expire_s) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = expire_s;

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates one SRAM-style bus between the fetch and data ports; data has
// priority, capped by MAX_D_BURST while a fetch waits. Optional watchdog: BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ice,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] inst_o,
    output logic          istall,
    input  logic          flush,
    input  logic          dce,
    input  logic [AW-1:0] daddr,
    input  logic [3:0]    we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dm_o,
    output logic          dstall,
    output logic          bus_req,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_we,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ready,
    output logic          bus_err
);

    localparam int BW = (MAX_D_BURST < 2) ? 1 : $clog2(MAX_D_BURST + 1);

    arb_state_t    state_r;
    arb_state_t    state_nxt_s;
    logic          i_done_r;
    logic          d_done_r;
    logic          flushed_r;
    logic [BW-1:0] burst_r;
    logic          bus_req_r;
    logic [AW-1:0] bus_addr_r;
    be_t           bus_we_r;
    logic [DW-1:0] bus_wdata_r;
    logic [DW-1:0] inst_r;
    logic [DW-1:0] dm_r;

    logic          i_pend_s;
    logic          d_pend_s;
    logic          can_grant_s;
    logic          burst_full_s;
    logic          d_grant_s;
    logic          i_grant_s;
    logic          i_end_s;
    logic          d_end_s;
    logic          i_keep_s;
    logic [DW-1:0] end_data_s;
    logic          wdog_expire_s;

    assign i_pend_s = ice & ~i_done_r;
    assign d_pend_s = dce & ~d_done_r;
    assign istall   = i_pend_s;
    assign dstall   = d_pend_s;

    // Grant decisions; nothing is granted while a done flag is still high.
    always_comb begin
        can_grant_s  = (state_r == ST_IDLE) && !i_done_r && !d_done_r;
        burst_full_s = (burst_r == BW'(MAX_D_BURST));
        d_grant_s    = 1'b0;
        i_grant_s    = 1'b0;
        if (can_grant_s && d_pend_s && !(i_pend_s && burst_full_s)) begin
            d_grant_s = 1'b1;
        end else if (can_grant_s && i_pend_s && !flush) begin
            i_grant_s = 1'b1;
        end else begin
            d_grant_s = 1'b0;
            i_grant_s = 1'b0;
        end
    end

    // Completion of the outstanding transaction, by bus_ready or by watchdog.
    always_comb begin
        i_end_s    = (state_r == ST_I_WAIT) && (bus_ready || wdog_expire_s);
        d_end_s    = (state_r == ST_D_WAIT) && (bus_ready || wdog_expire_s);
        i_keep_s   = i_end_s && !flushed_r && !flush;
        end_data_s = DW'(NOP_WORD);
        if (bus_ready) begin
            end_data_s = bus_rdata;
        end else begin
            end_data_s = DW'(NOP_WORD);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (d_grant_s) begin
                    state_nxt_s = ST_D_WAIT;
                end else if (i_grant_s) begin
                    state_nxt_s = ST_I_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_I_WAIT: begin
                if (i_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_I_WAIT;
                end
            end
            ST_D_WAIT: begin
                if (d_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_D_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and one-cycle done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            i_done_r <= i_keep_s;
            d_done_r <= d_end_s;
        end
    end

    // Bus request and controls are captured at grant and held until completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_r   <= 1'b0;
            bus_addr_r  <= '0;
            bus_we_r    <= '0;
            bus_wdata_r <= '0;
        end else if (d_grant_s) begin
            bus_req_r   <= 1'b1;
            bus_addr_r  <= daddr;
            bus_we_r    <= we;
            bus_wdata_r <= din;
        end else if (i_grant_s) begin
            bus_req_r   <= 1'b1;
            bus_addr_r  <= iaddr;
            bus_we_r    <= '0;
            bus_wdata_r <= '0;
        end else if (i_end_s || d_end_s) begin
            bus_req_r   <= 1'b0;
        end else begin
            bus_req_r   <= bus_req_r;
        end
    end

    // Returned words; stores and flushed fetches leave their register untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r <= '0;
            dm_r   <= '0;
        end else begin
            if (i_keep_s) begin
                inst_r <= end_data_s;
            end else begin
                inst_r <= inst_r;
            end
            if (d_end_s && (bus_we_r == '0)) begin
                dm_r <= end_data_s;
            end else begin
                dm_r <= dm_r;
            end
        end
    end

    // Flush marker for the fetch in flight; dropped once that fetch ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flushed_r <= 1'b0;
        end else if (state_r != ST_I_WAIT || i_end_s) begin
            flushed_r <= 1'b0;
        end else if (flush) begin
            flushed_r <= 1'b1;
        end else begin
            flushed_r <= flushed_r;
        end
    end

    // Data grants issued back-to-back while a fetch waits; saturates at the cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_r <= '0;
        end else if (i_grant_s || !ice) begin
            burst_r <= '0;
        end else if (d_grant_s && i_pend_s) begin
            burst_r <= burst_r + BW'(1);
        end else begin
            burst_r <= burst_r;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic bus_err_r;

    bus_arb_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (d_grant_s | i_grant_s),
        .clear  (i_end_s | d_end_s),
        .active (state_r != ST_IDLE),
        .expire (wdog_expire_s)
    );

    // Error pulse only when the watchdog, not the memory, ended the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= wdog_expire_s & ~bus_ready;
        end
    end

    assign bus_err = bus_err_r;
`else
    assign wdog_expire_s = 1'b0;
    assign bus_err       = 1'b0;
`endif

    assign bus_req   = bus_req_r;
    assign bus_addr  = bus_addr_r;
    assign bus_we    = bus_we_r;
    assign bus_wdata = bus_wdata_r;
    assign inst_o    = inst_r;
    assign dm_o      = dm_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; the timeout scenario is
// compiled in only with BUS_ARB_TIMEOUT_EN (DUT built with TIMEOUT_CYC=8).
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] inst_o;
    logic        istall;
    logic        flush;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dm_o;
    logic        dstall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(
        .AW          (32),
        .DW          (32),
        .MAX_D_BURST (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ice       (ice),
        .iaddr     (iaddr),
        .inst_o    (inst_o),
        .istall    (istall),
        .flush     (flush),
        .dce       (dce),
        .daddr     (daddr),
        .we        (we),
        .din       (din),
        .dm_o      (dm_o),
        .dstall    (dstall),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL rst_bus_addr got=%h exp=0", bus_addr); end
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", inst_o); end
        total++; if (dm_o !== 32'h0) begin bad++; $display("FAIL rst_dm got=%h exp=0", dm_o); end
        total++; if (istall !== 1'b0) begin bad++; $display("FAIL rst_istall got=%b exp=0", istall); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rst_bus_err got=%b exp=0", bus_err); end
        rst_n = 1'b1;
        tick();
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req got=%b exp=0", bus_req); end
    endtask

    task automatic test_single_fetch();
        ice = 1'b1; iaddr = 32'h100;
        #1;
        total++; if (istall !== 1'b1) begin bad++; $display("FAIL sf_istall_req got=%b exp=1", istall); end
        tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL sf_bus_req got=%b exp=1", bus_req); end
        total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL sf_bus_addr got=%h exp=100", bus_addr); end
        total++; if (bus_we !== 4'b0000) begin bad++; $display("FAIL sf_bus_we got=%b exp=0000", bus_we); end
        tick();
        tick();
        bus_ready = 1'b1; bus_rdata = 32'h2401_0005;
        #1;
        total++; if (istall !== 1'b1) begin bad++; $display("FAIL sf_istall_ready got=%b exp=1", istall); end
        tick();
        bus_ready = 1'b0; bus_rdata = 32'h0;
        total++; if (istall !== 1'b0) begin bad++; $display("FAIL sf_istall_done got=%b exp=0", istall); end
        total++; if (inst_o !== 32'h2401_0005) begin bad++; $display("FAIL sf_inst got=%h exp=24010005", inst_o); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL sf_req_drop got=%b exp=0", bus_req); end
        ice = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        ice = 1'b1; iaddr = 32'h300;
        dce = 1'b1; daddr = 32'h200; we = 4'b0000;
        tick();
        total++; if (bus_addr !== 32'h200) begin bad++; $display("FAIL prio_daddr got=%h exp=200", bus_addr); end
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ready = 1'b0;
        total++; if (dm_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL prio_dm got=%h exp=cafef00d", dm_o); end
        total++; if (dstall !== 1'b0) begin bad++; $display("FAIL prio_dstall got=%b exp=0", dstall); end
        total++; if (istall !== 1'b1) begin bad++; $display("FAIL prio_istall_d got=%b exp=1", istall); end
        dce = 1'b0;
        tick();
        total++; if (istall !== 1'b1) begin bad++; $display("FAIL prio_istall_gap got=%b exp=1", istall); end
        tick();
        total++; if (bus_addr !== 32'h300) begin bad++; $display("FAIL prio_iaddr got=%h exp=300", bus_addr); end
        bus_ready = 1'b1; bus_rdata = 32'h0000_1111;
        tick();
        bus_ready = 1'b0;
        total++; if (inst_o !== 32'h0000_1111) begin bad++; $display("FAIL prio_inst got=%h exp=00001111", inst_o); end
        total++; if (istall !== 1'b0) begin bad++; $display("FAIL prio_istall_done got=%b exp=0", istall); end
        ice = 1'b0;
        tick();
    endtask

    task automatic test_burst_cap();
        logic [31:0] exp_addr;
        ice = 1'b1; iaddr = 32'h400;
        dce = 1'b1; we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            exp_addr = 32'h500 + 32'(k * 4);
            daddr = exp_addr;
            tick();
            total++; if (bus_addr !== exp_addr) begin bad++; $display("FAIL burst_daddr%0d got=%h exp=%h", k, bus_addr, exp_addr); end
            bus_ready = 1'b1; bus_rdata = 32'hD000_0000 + 32'(k);
            tick();
            bus_ready = 1'b0;
            tick();
        end
        daddr = 32'h510;
        tick();
        total++; if (bus_addr !== 32'h400) begin bad++; $display("FAIL burst_fifth_fetch got=%h exp=400", bus_addr); end
        total++; if (dstall !== 1'b1) begin bad++; $display("FAIL burst_dstall got=%b exp=1", dstall); end
        bus_ready = 1'b1; bus_rdata = 32'h0000_F00D;
        tick();
        bus_ready = 1'b0;
        total++; if (inst_o !== 32'h0000_F00D) begin bad++; $display("FAIL burst_inst got=%h exp=0000f00d", inst_o); end
        ice = 1'b0;
        tick();
        tick();
        total++; if (bus_addr !== 32'h510) begin bad++; $display("FAIL burst_resume got=%h exp=510", bus_addr); end
        bus_ready = 1'b1; bus_rdata = 32'hD000_0004;
        tick();
        bus_ready = 1'b0;
        total++; if (dm_o !== 32'hD000_0004) begin bad++; $display("FAIL burst_dm got=%h exp=d0000004", dm_o); end
        dce = 1'b0;
        tick();
    endtask

    task automatic test_store();
        dce = 1'b1; daddr = 32'h600; we = 4'b0011; din = 32'hDEAD_BEEF;
        tick();
        total++; if (bus_we !== 4'b0011) begin bad++; $display("FAIL st_bus_we got=%b exp=0011", bus_we); end
        total++; if (bus_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_wdata got=%h exp=deadbeef", bus_wdata); end
        total++; if (bus_addr !== 32'h600) begin bad++; $display("FAIL st_addr got=%h exp=600", bus_addr); end
        bus_ready = 1'b1; bus_rdata = 32'h5555_5555;
        tick();
        bus_ready = 1'b0;
        total++; if (dm_o !== 32'hD000_0004) begin bad++; $display("FAIL st_dm_kept got=%h exp=d0000004", dm_o); end
        total++; if (dstall !== 1'b0) begin bad++; $display("FAIL st_dstall got=%b exp=0", dstall); end
        dce = 1'b0; we = 4'b0000; din = 32'h0;
        tick();
    endtask

    task automatic test_flush();
        ice = 1'b1; iaddr = 32'h700;
        tick();
        total++; if (bus_addr !== 32'h700) begin bad++; $display("FAIL fl_addr0 got=%h exp=700", bus_addr); end
        tick();
        flush = 1'b1; iaddr = 32'h800;
        tick();
        flush = 1'b0;
        bus_ready = 1'b1; bus_rdata = 32'h9999_9999;
        tick();
        bus_ready = 1'b0;
        total++; if (istall !== 1'b1) begin bad++; $display("FAIL fl_no_done got=%b exp=1", istall); end
        total++; if (inst_o !== 32'h0000_F00D) begin bad++; $display("FAIL fl_inst_kept got=%h exp=0000f00d", inst_o); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL fl_req_drop got=%b exp=0", bus_req); end
        tick();
        total++; if (bus_addr !== 32'h800) begin bad++; $display("FAIL fl_new_addr got=%h exp=800", bus_addr); end
        flush = 1'b1; bus_ready = 1'b1; bus_rdata = 32'hBAD0_BAD0; iaddr = 32'h900;
        tick();
        flush = 1'b0; bus_ready = 1'b0;
        total++; if (inst_o !== 32'h0000_F00D) begin bad++; $display("FAIL fl_sim_inst got=%h exp=0000f00d", inst_o); end
        total++; if (istall !== 1'b1) begin bad++; $display("FAIL fl_sim_istall got=%b exp=1", istall); end
        tick();
        total++; if (bus_addr !== 32'h900) begin bad++; $display("FAIL fl_addr2 got=%h exp=900", bus_addr); end
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        bus_ready = 1'b0;
        total++; if (inst_o !== 32'h1234_5678) begin bad++; $display("FAIL fl_inst_new got=%h exp=12345678", inst_o); end
        total++; if (istall !== 1'b0) begin bad++; $display("FAIL fl_istall_done got=%b exp=0", istall); end
        ice = 1'b0;
        tick();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic early_err;
        early_err = 1'b0;
        ice = 1'b1; iaddr = 32'hB00;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus_err === 1'b1) early_err = 1'b1;
        end
        total++; if (early_err !== 1'b0) begin bad++; $display("FAIL to_early_err got=%b exp=0", early_err); end
        total++; if (istall !== 1'b1) begin bad++; $display("FAIL to_istall_wait got=%b exp=1", istall); end
        tick();
        total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL to_bus_err got=%b exp=1", bus_err); end
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL to_inst_nop got=%h exp=0", inst_o); end
        total++; if (istall !== 1'b0) begin bad++; $display("FAIL to_istall got=%b exp=0", istall); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL to_req got=%b exp=0", bus_req); end
        tick();
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%b exp=0", bus_err); end
        ice = 1'b0;
        tick();
    endtask
`endif

    task automatic test_async_reset();
        dce = 1'b1; daddr = 32'hA00; we = 4'b0000;
        tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL ar_req_before got=%b exp=1", bus_req); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL ar_req got=%b exp=0", bus_req); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL ar_addr got=%h exp=0", bus_addr); end
        total++; if (dm_o !== 32'h0) begin bad++; $display("FAIL ar_dm got=%h exp=0", dm_o); end
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL ar_inst got=%h exp=0", inst_o); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL ar_err got=%b exp=0", bus_err); end
        dce = 1'b0;
        #1;
        total++; if (dstall !== 1'b0) begin bad++; $display("FAIL ar_dstall got=%b exp=0", dstall); end
        #3;
        rst_n = 1'b1;
        tick();
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL ar_idle got=%b exp=0", bus_req); end
    endtask

    initial begin
        rst_n = 1'b0; ice = 1'b0; iaddr = 32'h0; flush = 1'b0;
        dce = 1'b0; daddr = 32'h0; we = 4'b0000; din = 32'h0;
        bus_rdata = 32'h0; bus_ready = 1'b0;
        #12;
        test_reset();
        test_single_fetch();
        test_priority();
        test_burst_cap();
        test_store();
        test_flush();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
